macc_psum_drain: RTL



---
 rtl/macc_psum_drain_pkg.sv | 21 ++
 rtl/macc_psum_drain_if.sv | 22 ++
 rtl/requant_round_sat.sv | 52 +++++
 rtl/macc_psum_drain.sv | 139 +++++++++++++
 4 files changed

// File: rtl/macc_psum_drain_pkg.sv
// Shared widths, saturation limits and FSM encoding for the MACC partial-sum drain.
package macc_psum_drain_pkg;

    localparam int SUM_BITWIDTH   = 65;
    localparam int OUT_BITWIDTH   = 16;
    localparam int SHIFT_BITWIDTH = 6;
    localparam int CNT_BITWIDTH   = 16;

    // One guard bit so the rounding bias can never overflow the widest sum.
    localparam int MID_BITWIDTH   = SUM_BITWIDTH + 1;

    localparam logic signed [OUT_BITWIDTH-1:0] SAT_MAX = {1'b0, {(OUT_BITWIDTH-1){1'b1}}};
    localparam logic signed [OUT_BITWIDTH-1:0] SAT_MIN = {1'b1, {(OUT_BITWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/macc_psum_drain_if.sv
// Valid/ready streams of the drain: partial sums in from the PE column, results out downstream.
interface macc_psum_drain_if;

    logic signed [macc_psum_drain_pkg::SUM_BITWIDTH-1:0] sum_in;
    logic                                                sum_valid;
    logic                                                sum_ready;
    logic signed [macc_psum_drain_pkg::OUT_BITWIDTH-1:0] data_out;
    logic                                                data_out_valid;
    logic                                                data_out_ready;

    // The drain is the slave; the surrounding column/consumer pair is the master.
    modport master (
        output sum_in, sum_valid, data_out_ready,
        input  sum_ready, data_out, data_out_valid
    );

    modport slave (
        input  sum_in, sum_valid, data_out_ready,
        output sum_ready, data_out, data_out_valid
    );

endinterface

// File: rtl/requant_round_sat.sv
// Combinational requantization: round-half-up arithmetic shift, then ReLU and saturation.
// The two halves are exposed separately so the caller can register between them.
module requant_round_sat
    import macc_psum_drain_pkg::*;
(
    input  logic signed [SUM_BITWIDTH-1:0]   sum,
    input  logic        [SHIFT_BITWIDTH-1:0] shift,
    output logic signed [MID_BITWIDTH-1:0]   rounded,
    input  logic signed [MID_BITWIDTH-1:0]   value,
    input  logic                             relu,
    output logic signed [OUT_BITWIDTH-1:0]   result
);

    localparam logic signed [MID_BITWIDTH-1:0] HI_EXT =
        {{(MID_BITWIDTH-OUT_BITWIDTH){SAT_MAX[OUT_BITWIDTH-1]}}, SAT_MAX};
    localparam logic signed [MID_BITWIDTH-1:0] LO_EXT =
        {{(MID_BITWIDTH-OUT_BITWIDTH){SAT_MIN[OUT_BITWIDTH-1]}}, SAT_MIN};

    logic signed [MID_BITWIDTH-1:0] ext;
    logic signed [MID_BITWIDTH-1:0] half;
    logic signed [MID_BITWIDTH-1:0] biased;
    logic signed [MID_BITWIDTH-1:0] clipped;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        ext     = {sum[SUM_BITWIDTH-1], sum};
        half    = '0;
        biased  = ext;
        rounded = ext;
        if (shift == '0) begin
            rounded = ext;
        end else if (int'(shift) >= SUM_BITWIDTH) begin
            rounded = ext[MID_BITWIDTH-1] ? '1 : '0;
        end else begin
            half    = MID_BITWIDTH'(1) << (shift - SHIFT_BITWIDTH'(1));
            biased  = ext + half;
            rounded = biased >>> shift;
        end
    end

    always_comb begin
        clipped = (relu && value[MID_BITWIDTH-1]) ? '0 : value;
        if (clipped > HI_EXT) begin
            result = SAT_MAX;
        end else if (clipped < LO_EXT) begin
            result = SAT_MIN;
        end else begin
            result = clipped[OUT_BITWIDTH-1:0];
        end
    end

endmodule

// File: rtl/macc_psum_drain.sv
// Tail of the MACC chain: accepts a programmed number of partial sums per tile,
// requantizes them through a two-stage elastic pipeline and pulses done at the end.
module macc_psum_drain
    import macc_psum_drain_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cfg_start,
    input  logic [SHIFT_BITWIDTH-1:0] cfg_shift,
    input  logic                      cfg_relu,
    input  logic [CNT_BITWIDTH-1:0]   cfg_num_out,
    macc_psum_drain_if.slave          stream,
    output logic                      busy,
    output logic                      done
);

    state_t state;
    state_t state_nxt;

    logic [SHIFT_BITWIDTH-1:0] shift_q;
    logic                      relu_q;
    logic [CNT_BITWIDTH-1:0]   num_out_q;
    logic [CNT_BITWIDTH-1:0]   in_cnt;
    logic [CNT_BITWIDTH-1:0]   out_cnt;

    logic                           s1_valid;
    logic signed [MID_BITWIDTH-1:0] s1_data;
    logic signed [MID_BITWIDTH-1:0] rounded;
    logic                           out_valid;
    logic signed [OUT_BITWIDTH-1:0] out_data;
    logic signed [OUT_BITWIDTH-1:0] sat;

    logic start_fire;
    logic in_fire;
    logic out_fire;
    logic s1_adv;
    logic s2_adv;
    logic last_out;

    requant_round_sat u_requant (
        .sum     (stream.sum_in),
        .shift   (shift_q),
        .rounded (rounded),
        .value   (s1_data),
        .relu    (relu_q),
        .result  (sat)
    );

    // A stage may load when its successor is empty or is being drained this cycle.
    assign s2_adv     = !out_valid || stream.data_out_ready;
    assign s1_adv     = !s1_valid || s2_adv;
    assign start_fire = (state == ST_IDLE) && cfg_start;

    assign stream.sum_ready      = (state == ST_RUN) && (in_cnt < num_out_q) && s1_adv;
    assign stream.data_out       = out_data;
    assign stream.data_out_valid = out_valid;

    assign in_fire  = stream.sum_valid && stream.sum_ready;
    assign out_fire = out_valid && stream.data_out_ready;
    assign last_out = (out_cnt + CNT_BITWIDTH'(1)) == num_out_q;

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_nxt = (cfg_num_out == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (out_fire && last_out) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q   <= '0;
            relu_q    <= 1'b0;
            num_out_q <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
        end else if (start_fire) begin
            shift_q   <= cfg_shift;
            relu_q    <= cfg_relu;
            num_out_q <= cfg_num_out;
            in_cnt    <= '0;
            out_cnt   <= '0;
        end else begin
            // Both counters saturate at num_out because the handshakes stop there.
            if (in_fire) begin
                in_cnt <= in_cnt + CNT_BITWIDTH'(1);
            end
            if (out_fire) begin
                out_cnt <= out_cnt + CNT_BITWIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_fire;
                if (in_fire) begin
                    s1_data <= rounded;
                end
            end
            // Holding out_data while stalled keeps data_out stable for the consumer.
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= sat;
                end
            end
        end
    end

endmodule
